// File: rtl/cmd_arbiter.sv
// Front-end arbiter for cmd_engine: round-robin grant between CSR commands and XIP reads,
// registered config bundle and start pulse, completion strobes routed back to the granted requester.
module cmd_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter logic [7:0]  XIP_OPCODE     = 8'hEB,
  parameter logic [1:0]  XIP_ADDR_BYTES = 2'd1,
  parameter logic [1:0]  XIP_DATA_LANES = 2'd2,
  parameter logic [3:0]  XIP_DUMMY      = 4'd4,
  parameter logic        XIP_MODE_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  csr_trigger_i,
  input  logic [7:0]            csr_opcode_i,
  input  logic [ADDR_WIDTH-1:0] csr_addr_i,
  input  logic [31:0]           csr_len_i,
  input  logic                  csr_is_write_i,
  input  logic [1:0]            csr_addr_bytes_i,
  input  logic [1:0]            csr_data_lanes_i,
  input  logic [3:0]            csr_dummy_i,
  input  logic                  csr_mode_en_i,
  output logic                  csr_trigger_clr_o,
  output logic                  csr_done_set_o,
  input  logic                  xip_req_valid_i,
  output logic                  xip_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] xip_req_addr_i,
  input  logic [7:0]            xip_req_len_i,
  output logic                  xip_done_o,
  output logic                  cmd_start_o,
  input  logic                  cmd_trigger_clr_i,
  input  logic                  cmd_done_set_i,
  input  logic                  cmd_busy_i,
  output logic [7:0]            opcode_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [31:0]           len_o,
  output logic                  is_write_o,
  output logic [1:0]            addr_bytes_o,
  output logic [1:0]            data_lanes_o,
  output logic [3:0]            dummy_o,
  output logic                  mode_en_o,
  output logic                  owner_xip_o
);

  // 3-byte XIP addressing keeps only the low 24 bits; 0-byte addressing sends no address at all.
  localparam logic [ADDR_WIDTH-1:0] XIP_ADDR_MASK =
    (XIP_ADDR_BYTES == 2'd0) ? {ADDR_WIDTH{1'b0}} :
    (XIP_ADDR_BYTES == 2'd1) ? ADDR_WIDTH'(32'h00FF_FFFF) : {ADDR_WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t state;
  logic   prefer_xip;
  logic   idle_free;
  logic   grant_xip;
  logic   grant_csr;

  assign idle_free         = (state == IDLE) && !cmd_busy_i;
  assign grant_xip         = idle_free && xip_req_valid_i && (!csr_trigger_i || prefer_xip);
  assign grant_csr         = idle_free && csr_trigger_i && !grant_xip;
  assign xip_req_ready_o   = grant_xip;
  assign csr_trigger_clr_o = (state != IDLE) && !owner_xip_o && cmd_trigger_clr_i;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      prefer_xip     <= 1'b0;
      cmd_start_o    <= 1'b0;
      csr_done_set_o <= 1'b0;
      xip_done_o     <= 1'b0;
      owner_xip_o    <= 1'b0;
      opcode_o       <= '0;
      addr_o         <= '0;
      len_o          <= '0;
      is_write_o     <= 1'b0;
      addr_bytes_o   <= '0;
      data_lanes_o   <= '0;
      dummy_o        <= '0;
      mode_en_o      <= 1'b0;
    end else begin
      cmd_start_o    <= 1'b0;
      csr_done_set_o <= 1'b0;
      xip_done_o     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_xip) begin
            owner_xip_o  <= 1'b1;
            opcode_o     <= XIP_OPCODE;
            addr_o       <= xip_req_addr_i & XIP_ADDR_MASK;
            len_o        <= {24'd0, xip_req_len_i};
            is_write_o   <= 1'b0;
            addr_bytes_o <= XIP_ADDR_BYTES;
            data_lanes_o <= XIP_DATA_LANES;
            dummy_o      <= XIP_DUMMY;
            mode_en_o    <= XIP_MODE_EN;
            // Zero-length reads never reach the engine; complete them locally.
            if (xip_req_len_i == 8'd0) begin
              xip_done_o <= 1'b1;
              prefer_xip <= 1'b0;
            end else begin
              cmd_start_o <= 1'b1;
              state       <= ISSUE;
            end
          end else if (grant_csr) begin
            owner_xip_o  <= 1'b0;
            opcode_o     <= csr_opcode_i;
            addr_o       <= csr_addr_i;
            len_o        <= csr_len_i;
            is_write_o   <= csr_is_write_i;
            addr_bytes_o <= csr_addr_bytes_i;
            data_lanes_o <= csr_data_lanes_i;
            dummy_o      <= csr_dummy_i;
            mode_en_o    <= csr_mode_en_i;
            cmd_start_o  <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: state <= WAIT_BUSY;
        WAIT_BUSY: begin
          if (cmd_busy_i) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (cmd_done_set_i) begin
            csr_done_set_o <= !owner_xip_o;
            xip_done_o     <= owner_xip_o;
            prefer_xip     <= !owner_xip_o;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_arbiter.sv
// Randomized bench for cmd_arbiter: drives CSR/XIP requesters and a cmd_engine stand-in,
// predicting grants, config values and strobe routing from a round-robin reference model.
module tb_cmd_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        csr_trigger_i;
  logic [7:0]  csr_opcode_i;
  logic [31:0] csr_addr_i;
  logic [31:0] csr_len_i;
  logic        csr_is_write_i;
  logic [1:0]  csr_addr_bytes_i;
  logic [1:0]  csr_data_lanes_i;
  logic [3:0]  csr_dummy_i;
  logic        csr_mode_en_i;
  logic        csr_trigger_clr_o;
  logic        csr_done_set_o;
  logic        xip_req_valid_i;
  logic        xip_req_ready_o;
  logic [31:0] xip_req_addr_i;
  logic [7:0]  xip_req_len_i;
  logic        xip_done_o;
  logic        cmd_start_o;
  logic        cmd_trigger_clr_i;
  logic        cmd_done_set_i;
  logic        cmd_busy_i;
  logic [7:0]  opcode_o;
  logic [31:0] addr_o;
  logic [31:0] len_o;
  logic        is_write_o;
  logic [1:0]  addr_bytes_o;
  logic [1:0]  data_lanes_o;
  logic [3:0]  dummy_o;
  logic        mode_en_o;
  logic        owner_xip_o;

  cmd_arbiter dut (
    .clk(clk), .resetn(resetn),
    .csr_trigger_i(csr_trigger_i), .csr_opcode_i(csr_opcode_i), .csr_addr_i(csr_addr_i),
    .csr_len_i(csr_len_i), .csr_is_write_i(csr_is_write_i), .csr_addr_bytes_i(csr_addr_bytes_i),
    .csr_data_lanes_i(csr_data_lanes_i), .csr_dummy_i(csr_dummy_i), .csr_mode_en_i(csr_mode_en_i),
    .csr_trigger_clr_o(csr_trigger_clr_o), .csr_done_set_o(csr_done_set_o),
    .xip_req_valid_i(xip_req_valid_i), .xip_req_ready_o(xip_req_ready_o),
    .xip_req_addr_i(xip_req_addr_i), .xip_req_len_i(xip_req_len_i), .xip_done_o(xip_done_o),
    .cmd_start_o(cmd_start_o), .cmd_trigger_clr_i(cmd_trigger_clr_i),
    .cmd_done_set_i(cmd_done_set_i), .cmd_busy_i(cmd_busy_i),
    .opcode_o(opcode_o), .addr_o(addr_o), .len_o(len_o), .is_write_o(is_write_o),
    .addr_bytes_o(addr_bytes_o), .data_lanes_o(data_lanes_o), .dummy_o(dummy_o),
    .mode_en_o(mode_en_o), .owner_xip_o(owner_xip_o)
  );

  always #5 clk = ~clk;

  logic [87:0] all_out;
  assign all_out = {cmd_start_o, csr_trigger_clr_o, csr_done_set_o, xip_req_ready_o, xip_done_o,
                    opcode_o, addr_o, len_o, is_write_o, addr_bytes_o, data_lanes_o, dummy_o,
                    mode_en_o, owner_xip_o};

  int vec  = 0;
  int errs = 0;
  int acc_cnt = 0;
  bit m_last_xip = 1'b1;  // reference model: owner of the last completed grant

  // Both pending -> opposite of the last grant; otherwise whoever is pending.
  function automatic bit model_pick_xip(input bit csr_p, input bit xip_p);
    return xip_p && (!csr_p || !m_last_xip);
  endfunction

  // Plays requesters and engine for one command. rearm keeps both request lines asserted.
  task automatic serve(input bit rearm, input int bdly, input int ddly, output int lat,
                       output bit own, output bit clr_seen, output bit early_d,
                       output bit csr_d, output bit xip_d);
    bit drop;
    bit got;
    lat = -1; own = 1'b0; got = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      drop = 1'b0;
      if (xip_req_valid_i && xip_req_ready_o) begin acc_cnt++; drop = !rearm; end
      if (cmd_start_o) begin got = 1'b1; lat = i; own = owner_xip_o; end
      @(posedge clk); #1;
      if (drop) xip_req_valid_i = 1'b0;
    end
    repeat (bdly) begin @(posedge clk); #1; end
    cmd_busy_i = 1'b1; cmd_trigger_clr_i = 1'b1;
    @(negedge clk); clr_seen = csr_trigger_clr_o;
    @(posedge clk); #1;
    cmd_trigger_clr_i = 1'b0;
    if (clr_seen && !rearm) csr_trigger_i = 1'b0;
    repeat (ddly) begin @(posedge clk); #1; end
    if (!rearm) begin csr_trigger_i = 1'b0; xip_req_valid_i = 1'b0; end
    cmd_done_set_i = 1'b1;
    @(negedge clk); early_d = csr_done_set_o | xip_done_o;
    @(posedge clk); #1;
    cmd_done_set_i = 1'b0; cmd_busy_i = 1'b0;
    @(negedge clk);
    csr_d = csr_done_set_o; xip_d = xip_done_o;
    if (xip_req_valid_i && xip_req_ready_o) acc_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic rand_csr();
    csr_addr_i = $urandom(); csr_len_i = $urandom_range(4096, 1);
    csr_opcode_i = 8'($urandom()); csr_is_write_i = 1'($urandom());
    csr_addr_bytes_i = 2'($urandom_range(2, 0)); csr_data_lanes_i = 2'($urandom_range(2, 0));
    csr_dummy_i = 4'($urandom()); csr_mode_en_i = 1'($urandom());
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    {csr_trigger_i, csr_is_write_i, csr_mode_en_i, xip_req_valid_i} = '0;
    {cmd_trigger_clr_i, cmd_done_set_i, cmd_busy_i} = '0;
    csr_opcode_i = '0; csr_addr_i = '0; csr_len_i = '0; csr_addr_bytes_i = '0;
    csr_data_lanes_i = '0; csr_dummy_i = '0; xip_req_addr_i = '0; xip_req_len_i = '0;
    repeat (2) @(negedge clk);
    vec++; if (all_out !== '0) begin errs++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    vec++; if (all_out !== '0) begin errs++; $display("FAIL post_reset_idle: got %h want 0", all_out); end
    m_last_xip = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_csr_only();
    int lat; bit own, clr, early, cd, xd;
    logic [87:0] exp_cfg;
    for (int n = 0; n < 4; n++) begin
      rand_csr();
      if (n == 0) begin csr_opcode_i = 8'h03; csr_len_i = 32'd16; end
      exp_cfg = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, csr_opcode_i, csr_addr_i, csr_len_i, csr_is_write_i,
                 csr_addr_bytes_i, csr_data_lanes_i, csr_dummy_i, csr_mode_en_i, 1'b0};
      csr_trigger_i = 1'b1;
      serve(1'b0, $urandom_range(3, 0), $urandom_range(5, 0), lat, own, clr, early, cd, xd);
      vec++; if (lat !== 2) begin errs++; $display("FAIL csr_start_latency: got %0d want 2", lat); end
      vec++; if (own !== 1'b0) begin errs++; $display("FAIL csr_owner: got %b want 0", own); end
      vec++; if (clr !== 1'b1) begin errs++; $display("FAIL csr_clr_forward: got %b want 1", clr); end
      vec++; if (early !== 1'b0) begin errs++; $display("FAIL csr_done_early: got %b want 0", early); end
      vec++; if ({cd, xd} !== 2'b10) begin errs++; $display("FAIL csr_done_route: got csr=%b xip=%b want csr=1 xip=0", cd, xd); end
      vec++; if (all_out !== exp_cfg) begin errs++; $display("FAIL csr_config_hold: got %h want %h", all_out, exp_cfg); end
      m_last_xip = 1'b0;
    end
  endtask

  task automatic test_xip_only();
    int lat, a0; bit own, clr, early, cd, xd;
    logic [87:0] exp_cfg;
    for (int n = 0; n < 4; n++) begin
      xip_req_addr_i = $urandom(); xip_req_len_i = 8'($urandom_range(255, 1));
      if (n == 0) begin xip_req_addr_i = 32'hAB12_3456; xip_req_len_i = 8'd32; end
      exp_cfg = {5'b0, 8'hEB, xip_req_addr_i & 32'h00FF_FFFF, 24'd0, xip_req_len_i,
                 1'b0, 2'd1, 2'd2, 4'd4, 1'b1, 1'b1};
      a0 = acc_cnt;
      xip_req_valid_i = 1'b1;
      serve(1'b0, $urandom_range(3, 0), $urandom_range(5, 0), lat, own, clr, early, cd, xd);
      vec++; if (lat !== 2) begin errs++; $display("FAIL xip_start_latency: got %0d want 2", lat); end
      vec++; if (acc_cnt - a0 !== 1) begin errs++; $display("FAIL xip_accept_count: got %0d want 1", acc_cnt - a0); end
      vec++; if (own !== 1'b1) begin errs++; $display("FAIL xip_owner: got %b want 1", own); end
      vec++; if (clr !== 1'b0) begin errs++; $display("FAIL xip_clr_blocked: got %b want 0", clr); end
      vec++; if ({cd, xd} !== 2'b01) begin errs++; $display("FAIL xip_done_route: got csr=%b xip=%b want csr=0 xip=1", cd, xd); end
      vec++; if (all_out !== exp_cfg) begin errs++; $display("FAIL xip_config: got %h want %h", all_out, exp_cfg); end
      m_last_xip = 1'b1;
    end
  endtask

  task automatic test_xip_len0();
    int lat; bit own, clr, early, cd, xd, exp_x;
    xip_req_addr_i = $urandom(); xip_req_len_i = 8'd0; xip_req_valid_i = 1'b1;
    @(negedge clk);
    vec++; if (xip_req_ready_o !== 1'b1) begin errs++; $display("FAIL len0_accept: got %b want 1", xip_req_ready_o); end
    @(posedge clk); #1 xip_req_valid_i = 1'b0;
    @(negedge clk);
    vec++; if ({xip_done_o, cmd_start_o} !== 2'b10) begin errs++; $display("FAIL len0_done_pulse: got done=%b start=%b want done=1 start=0", xip_done_o, cmd_start_o); end
    @(posedge clk); #1;
    @(negedge clk);
    vec++; if ({xip_done_o, cmd_start_o} !== 2'b00) begin errs++; $display("FAIL len0_after: got done=%b start=%b want 0 0", xip_done_o, cmd_start_o); end
    m_last_xip = 1'b1;
    @(posedge clk); #1;
    rand_csr(); xip_req_len_i = 8'($urandom_range(255, 1));
    csr_trigger_i = 1'b1; xip_req_valid_i = 1'b1;
    exp_x = model_pick_xip(1'b1, 1'b1);
    serve(1'b1, $urandom_range(2, 0), $urandom_range(3, 0), lat, own, clr, early, cd, xd);
    vec++; if (own !== exp_x) begin errs++; $display("FAIL len0_rr_next: got %b want %b", own, exp_x); end
    m_last_xip = exp_x;
    exp_x = model_pick_xip(1'b1, 1'b1);
    serve(1'b0, $urandom_range(2, 0), $urandom_range(3, 0), lat, own, clr, early, cd, xd);
    vec++; if (own !== exp_x) begin errs++; $display("FAIL len0_rr_second: got %b want %b", own, exp_x); end
    m_last_xip = exp_x;
  endtask

  task automatic test_busy_block();
    int lat; bit own, clr, early, cd, xd, seen, exp_x;
    rand_csr(); xip_req_addr_i = $urandom(); xip_req_len_i = 8'($urandom_range(255, 1));
    cmd_busy_i = 1'b1; csr_trigger_i = 1'b1; xip_req_valid_i = 1'b1;
    seen = 1'b0;
    repeat ($urandom_range(6, 2)) begin
      @(negedge clk); seen |= xip_req_ready_o | cmd_start_o;
      @(posedge clk); #1;
    end
    vec++; if (seen !== 1'b0) begin errs++; $display("FAIL busy_no_grant: got %b want 0", seen); end
    cmd_busy_i = 1'b0;
    exp_x = model_pick_xip(1'b1, 1'b1);
    serve(1'b0, $urandom_range(3, 0), $urandom_range(3, 0), lat, own, clr, early, cd, xd);
    vec++; if (lat !== 2) begin errs++; $display("FAIL busy_release_latency: got %0d want 2", lat); end
    vec++; if (own !== exp_x) begin errs++; $display("FAIL busy_release_owner: got %b want %b", own, exp_x); end
    m_last_xip = exp_x;
  endtask

  task automatic test_back_to_back();
    int lat; bit own, clr, early, cd, xd, exp_x;
    rand_csr(); xip_req_addr_i = $urandom(); xip_req_len_i = 8'($urandom_range(255, 1));
    csr_trigger_i = 1'b1; xip_req_valid_i = 1'b1;
    for (int n = 0; n < 4; n++) begin
      exp_x = model_pick_xip(1'b1, 1'b1);
      serve(n != 3, $urandom_range(3, 0), $urandom_range(4, 0), lat, own, clr, early, cd, xd);
      vec++; if (lat < 1) begin errs++; $display("FAIL b2b_start_%0d: got %0d want >=1", n, lat); end
      vec++; if (own !== exp_x) begin errs++; $display("FAIL b2b_owner_%0d: got %b want %b", n, own, exp_x); end
      vec++; if (clr !== !exp_x) begin errs++; $display("FAIL b2b_clr_%0d: got %b want %b", n, clr, !exp_x); end
      vec++; if ({early, cd, xd} !== {1'b0, !exp_x, exp_x}) begin errs++; $display("FAIL b2b_done_%0d: got early=%b csr=%b xip=%b want 0 %b %b", n, early, cd, xd, !exp_x, exp_x); end
      m_last_xip = exp_x;
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit own, clr, early, cd, xd, got, exp_x;
    rand_csr(); csr_trigger_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = cmd_start_o; end
    vec++; if (got !== 1'b1) begin errs++; $display("FAIL mid_start_seen: got %b want 1", got); end
    @(posedge clk); #1 cmd_busy_i = 1'b1; cmd_trigger_clr_i = 1'b1;
    @(posedge clk); #1 cmd_trigger_clr_i = 1'b0; csr_trigger_i = 1'b0;
    @(posedge clk); #1 resetn = 1'b0;
    #2;
    vec++; if (all_out !== '0) begin errs++; $display("FAIL mid_reset_outputs: got %h want 0", all_out); end
    @(posedge clk); #1 resetn = 1'b1; cmd_done_set_i = 1'b1;
    m_last_xip = 1'b1;
    @(negedge clk);
    vec++; if ({csr_done_set_o, xip_done_o, cmd_start_o} !== 3'b000) begin errs++; $display("FAIL stray_done_a: got %b want 000", {csr_done_set_o, xip_done_o, cmd_start_o}); end
    @(posedge clk); #1 cmd_done_set_i = 1'b0; cmd_busy_i = 1'b0;
    @(negedge clk);
    vec++; if ({csr_done_set_o, xip_done_o, cmd_start_o} !== 3'b000) begin errs++; $display("FAIL stray_done_b: got %b want 000", {csr_done_set_o, xip_done_o, cmd_start_o}); end
    @(posedge clk); #1;
    xip_req_addr_i = $urandom(); xip_req_len_i = 8'($urandom_range(255, 1));
    csr_trigger_i = 1'b1; xip_req_valid_i = 1'b1;
    exp_x = model_pick_xip(1'b1, 1'b1);
    serve(1'b0, $urandom_range(2, 0), $urandom_range(2, 0), lat, own, clr, early, cd, xd);
    vec++; if (own !== exp_x) begin errs++; $display("FAIL rr_after_reset: got %b want %b", own, exp_x); end
    vec++; if (lat !== 2) begin errs++; $display("FAIL rr_after_reset_latency: got %0d want 2", lat); end
    m_last_xip = exp_x;
  endtask

  initial begin
    test_reset();
    test_csr_only();
    test_xip_only();
    test_xip_len0();
    test_busy_block();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
